ibex_dummy_instr_insert: RTL

IF-to-ID pipeline register with dummy instruction insertion, sitting directly downstream of the dummy instruction generator in the IF stage. It merges the generator's insertion request and instruction word into the real fetch stream, and stalls the prefetch buffer for the cycle a dummy is issued. Each instruction handed to ID carries a dummy flag, so ID/WB can suppress side effects and retirement for dummies. It also bounds back-to-back dummies and keeps a saturating count of dummies issued.

---
 rtl/ibex_dummy_instr_insert.sv | 113 +++++++++++
 1 files changed

// File: rtl/ibex_dummy_instr_insert.sv
// ibex_dummy_instr_insert
//   IF-to-ID pipeline register that merges dummy instructions from the dummy
//   instruction generator into the real fetch stream. Each instruction handed
//   to ID carries a dummy flag. Back-to-back dummies are bounded, and a
//   saturating counter tracks how many dummies were issued.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   fetch_*_i / fetch_ready_o  prefetch buffer handshake (ready is combinational)
//   insert_dummy_instr_i     generator insertion request
//   dummy_instr_data_i       generator dummy instruction word
//   dummy_taken_o            dummy issued this cycle (combinational)
//   id_in_ready_i            ID accepts a new instruction
//   flush_i                  pipeline flush, kills the register contents
//   instr_*_id_o, instr_fetch_err_o, instr_is_dummy_o  registered ID outputs
//   cnt_clr_i / dummy_cnt_o  dummy counter clear / saturating count
module ibex_dummy_instr_insert #(
  parameter int unsigned MaxConsecDummy = 2,
  parameter int unsigned CntW           = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            fetch_valid_i,
  input  logic [31:0]     fetch_rdata_i,
  input  logic [31:0]     fetch_addr_i,
  input  logic            fetch_err_i,
  output logic            fetch_ready_o,
  input  logic            insert_dummy_instr_i,
  input  logic [31:0]     dummy_instr_data_i,
  output logic            dummy_taken_o,
  input  logic            id_in_ready_i,
  input  logic            flush_i,
  output logic            instr_valid_id_o,
  output logic [31:0]     instr_rdata_id_o,
  output logic [31:0]     instr_pc_id_o,
  output logic            instr_fetch_err_o,
  output logic            instr_is_dummy_o,
  input  logic            cnt_clr_i,
  output logic [CntW-1:0] dummy_cnt_o
);

  localparam int unsigned ConsecW = $clog2(MaxConsecDummy + 1);

  logic [ConsecW-1:0] consec_q;
  logic               valid_q;
  logic [31:0]        rdata_q;
  logic [31:0]        pc_q;
  logic               err_q;
  logic               dummy_q;
  logic [CntW-1:0]    cnt_q;

  logic block;
  logic insert_eff;
  logic real_load;

  // Insertion is masked once the back-to-back limit is reached, and on flush.
  assign block         = (consec_q == ConsecW'(MaxConsecDummy));
  assign insert_eff    = insert_dummy_instr_i & ~block & ~flush_i;
  assign dummy_taken_o = insert_eff & id_in_ready_i;
  assign fetch_ready_o = id_in_ready_i & ~insert_eff & ~flush_i;
  assign real_load     = fetch_ready_o & fetch_valid_i;

  // ID pipeline register and consecutive-dummy tracker.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      rdata_q  <= 32'h0;
      pc_q     <= 32'h0;
      err_q    <= 1'b0;
      dummy_q  <= 1'b0;
      consec_q <= '0;
    end else if (flush_i) begin
      valid_q  <= 1'b0;
      consec_q <= '0;
    end else if (dummy_taken_o) begin
      // The real instruction stays in the prefetch buffer; the dummy borrows its PC.
      valid_q  <= 1'b1;
      rdata_q  <= dummy_instr_data_i;
      pc_q     <= fetch_addr_i;
      err_q    <= 1'b0;
      dummy_q  <= 1'b1;
      consec_q <= consec_q + ConsecW'(1);
    end else if (real_load) begin
      valid_q  <= 1'b1;
      rdata_q  <= fetch_rdata_i;
      pc_q     <= fetch_addr_i;
      err_q    <= fetch_err_i;
      dummy_q  <= 1'b0;
      consec_q <= '0;
    end else if (id_in_ready_i) begin
      valid_q  <= 1'b0;
    end
  end

  // Saturating issued-dummy counter; clear wins over increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (cnt_clr_i) begin
      cnt_q <= '0;
    end else if (dummy_taken_o && !(&cnt_q)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign instr_valid_id_o  = valid_q;
  assign instr_rdata_id_o  = rdata_q;
  assign instr_pc_id_o     = pc_q;
  assign instr_fetch_err_o = err_q;
  assign instr_is_dummy_o  = dummy_q;
  assign dummy_cnt_o       = cnt_q;

endmodule
